// File: rtl/led_pattern_scheduler.sv
// Shared-timebase LED scheduler: one free-running prescaler tick drives up to
// four independently commanded LED channels (OFF / ON / BLINK / FLASH-N).
module led_pattern_scheduler #(
   parameter int unsigned NUM_LEDS = 4,
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned CW       = 27
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_led,
   input  logic [1:0]          cmd_mode,
   input  logic [7:0]          cmd_count,
   output logic                tick,
   output logic [NUM_LEDS-1:0] led_out,
   output logic [NUM_LEDS-1:0] busy
);

   localparam int unsigned FW = 9;
   localparam logic [CW-1:0] PRE_LAST = CW'(TICK_DIV - 1);

   localparam logic [1:0] MODE_OFF   = 2'd0;
   localparam logic [1:0] MODE_ON    = 2'd1;
   localparam logic [1:0] MODE_BLINK = 2'd2;
   localparam logic [1:0] MODE_FLASH = 2'd3;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ON    = 2'd1,
      ST_BLINK = 2'd2,
      ST_FLASH = 2'd3
   } state_e;

   logic [CW-1:0]       pre_q, pre_d;
   state_e              state_q [NUM_LEDS];
   state_e              state_d [NUM_LEDS];
   logic [FW-1:0]       rem_q   [NUM_LEDS];
   logic [FW-1:0]       rem_d   [NUM_LEDS];
   logic [NUM_LEDS-1:0] led_q, led_d;
   logic [NUM_LEDS-1:0] busy_q, busy_d;
   logic [3:0]          busy_pad;
   logic                accept;

   // Channels beyond NUM_LEDS read as idle, so commands to them are taken and dropped
   assign busy_pad  = 4'(busy_q);
   assign cmd_ready = ~busy_pad[cmd_led];
   assign accept    = cmd_valid & cmd_ready;
   assign tick      = (pre_q == PRE_LAST);
   assign led_out   = led_q;
   assign busy      = busy_q;

   // Free-running prescaler, wraps after TICK_DIV cycles
   always_comb begin
      pre_d = pre_q + CW'(1);
      if (pre_q == PRE_LAST) begin
         pre_d = '0;
      end
   end

   // Per-channel next state: an accepted command wins over a same-edge tick
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      led_d   = led_q;
      busy_d  = busy_q;
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (accept && (cmd_led == 2'(i))) begin
            unique case (cmd_mode)
               MODE_OFF: begin
                  state_d[i] = ST_OFF;
                  led_d[i]   = 1'b0;
               end
               MODE_ON: begin
                  state_d[i] = ST_ON;
                  led_d[i]   = 1'b1;
               end
               MODE_BLINK: begin
                  state_d[i] = ST_BLINK;
                  led_d[i]   = 1'b1;
               end
               MODE_FLASH: begin
                  if (cmd_count == 8'd0) begin
                     state_d[i] = ST_OFF;
                     led_d[i]   = 1'b0;
                     rem_d[i]   = '0;
                  end else begin
                     state_d[i] = ST_FLASH;
                     led_d[i]   = 1'b1;
                     busy_d[i]  = 1'b1;
                     rem_d[i]   = {cmd_count, 1'b0};
                  end
               end
            endcase
         end else if (tick) begin
            case (state_q[i])
               ST_BLINK: led_d[i] = ~led_q[i];
               ST_FLASH: begin
                  rem_d[i] = rem_q[i] - FW'(1);
                  if (rem_q[i] == FW'(1)) begin
                     // Last toggle of the flash ends dark and frees the channel
                     state_d[i] = ST_OFF;
                     led_d[i]   = 1'b0;
                     busy_d[i]  = 1'b0;
                  end else begin
                     led_d[i] = ~led_q[i];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         led_q  <= '0;
         busy_q <= '0;
         for (int i = 0; i < NUM_LEDS; i++) begin
            state_q[i] <= ST_OFF;
            rem_q[i]   <= '0;
         end
      end else begin
         pre_q   <= pre_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

endmodule

// File: doc/led_pattern_scheduler.md
# led_pattern_scheduler

Shared-timebase LED scheduler. A single free-running prescaler produces a periodic tick, and that tick is shared among up to four LED channels. Each channel is independently commanded over a valid/ready interface to OFF, ON, BLINK or FLASH-N. The block sits between board-level control logic and the `led_out` pins, and replaces per-LED divider counters.

## Interface

Parameters:
- `NUM_LEDS`, default 4: number of LED channels, valid range 1..4.
- `TICK_DIV`, default 100000000: `clk` cycles per tick; 1 s at 100 MHz; must be ≥ 2.
- `CW`, default 27: prescaler width; must satisfy 2^CW ≥ TICK_DIV.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: command can be accepted.
- `cmd_led`, in, 2: target channel index.
- `cmd_mode`, in, 2: 0 = OFF, 1 = ON, 2 = BLINK, 3 = FLASH.
- `cmd_count`, in, 8: FLASH on/off cycle count N.
- `tick`, out, 1: one-cycle timebase strobe.
- `led_out`, out, NUM_LEDS: LED drive, registered.
- `busy`, out, NUM_LEDS: channel is executing FLASH, registered.

## Operation

**Prescaler**
- Counts 0..TICK_DIV-1, then wraps to 0.
- `tick` = (prescaler == TICK_DIV-1), combinational decode.
- Free-running; never reset or realigned by commands.

**Command acceptance**
- `cmd_ready` = !busy[cmd_led] when cmd_led < NUM_LEDS; 1 otherwise.
- `cmd_ready` is combinational from `cmd_led` and `busy`. It does not depend on `cmd_valid`.
- A command is accepted on a rising edge where cmd_valid && cmd_ready.
- If cmd_led ≥ NUM_LEDS, the command is accepted and discarded.

**Per-channel state machine**, states OFF, ON, BLINK, FLASH:
- OFF: led = 0.
- ON: led = 1.
- BLINK: led = 1 on the accept edge, then toggles on every tick edge, indefinitely.
- FLASH with N > 0:
  - On the accept edge: led = 1, busy = 1, remaining-toggle counter = 2N (9 bits).
  - Each tick edge toggles led and decrements the counter.
  - On the edge where the counter reaches 0, led = 0, busy = 0, and the state becomes OFF.
- FLASH with N = 0: equivalent to OFF; busy stays 0.
- Any accepted command overrides the channel's current OFF/ON/BLINK state immediately. FLASH cannot be overridden because `cmd_ready` is 0 while the channel is busy.
- A BLINK command issued to a channel already in BLINK restarts it with led = 1.

**Boundary conditions**
- Accept and tick on the same edge for the same channel: the command wins and the tick is ignored for that channel only. Other channels still see the tick.
- Tick and FLASH final toggle: busy falls on the same edge that led goes to 0. A new command to that channel can be accepted on the next edge.
- Commands to different channels are fully independent.

## Timing

- Reset (rst = 0), applied asynchronously:
  - prescaler = 0, all channels OFF.
  - led_out = 0, busy = 0, tick = 0, cmd_ready = 1.
  - No command is accepted while rst = 0.
- After rst deasserts, `tick` is first high in cycle TICK_DIV-1, counting the first clocked cycle as 0. It then repeats every TICK_DIV cycles.
- Command latency: the new led/busy value is visible on the output one edge after cmd_valid && cmd_ready is sampled.
- Tick response: led toggles on the edge that ends the cycle in which tick = 1.
- FLASH-N duration: exactly 2N tick edges from accept to busy falling. The first on-phase is partial, because the tick phase is not aligned to the command.
- Reset asserted mid-FLASH or mid-BLINK: all outputs go to 0 immediately, without waiting for a clock edge.

## Test plan

Bench uses TICK_DIV = 4 and NUM_LEDS = 4.

1. **Reset and tick cadence.** Hold rst = 0 for 3 cycles → led_out = 4'b0000, busy = 0, tick = 0, cmd_ready = 1. Release rst → tick high in cycles 3, 7, 11, and low in all other cycles.
2. **ON/OFF.** Accept (led 2, ON) → led_out = 4'b0100 on the next edge. Accept (led 2, OFF) → led_out = 4'b0000.
3. **BLINK.** Accept (led 0, BLINK) → led0 = 1. After the 1st, 2nd and 3rd following ticks, led0 = 0, 1, 0. led1–led3 unchanged.
4. **FLASH and handshake.** Accept (led 1, FLASH, N = 2) → busy = 4'b0010.
   - cmd_ready = 0 while cmd_led = 1; cmd_ready = 1 while cmd_led = 3.
   - Accept (led 3, ON) during the flash → led3 = 1.
   - led1 sequence 1,0,1,0 across 4 ticks. busy[1] falls on the 4th tick edge; cmd_ready for led 1 returns to 1.
5. **Edge cases.**
   - Accept (led 0, FLASH, N = 0) → led0 = 0, busy = 0.
   - Accept (led 0, ON) on a tick edge while led0 is in BLINK with led0 = 1 → led0 = 1, no toggle. The same tick still toggles another blinking LED.
6. **Reset mid-operation.** With led 1 in FLASH N = 3 and led 0 in BLINK, drive rst = 0 between clock edges → led_out = 0 and busy = 0 before the next edge. After release, tick realigns to cycle 3.
